gseq_series_acc: RTL and testbench

Synthesizable downstream consumer of the geometric-sequence term stream (terms a1*k^i, unsigned 64-bit, saturated terms carried as the OVF sentinel word).
Accumulates terms into running partial sums S_i = sum of terms 0..i and streams each partial sum out with its 1-based index.
Propagates and detects overflow.
Sits between the term generator and the display/check logic.

---
 rtl/gseq_pkg.sv | 21 ++
 rtl/gseq_sat_add.sv | 33 +++
 rtl/gseq_series_acc.sv | 131 +++++++++++++
 tb/tb_gseq_series_acc.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gseq_pkg.sv
// Shared constants and types for the geometric-sequence term generator and
// its downstream series accumulator.
//   W        : term / partial-sum width
//   N        : default number of terms per sequence
//   OVF_WORD : sentinel word ("ovf") carried in place of a saturated value
//   MAX_WORD : all-ones word; a sum reaching it is treated as overflow
//   state_t  : accumulator FSM states
package gseq_pkg;

  localparam int unsigned W = 64;
  localparam int unsigned N = 10;

  localparam logic [W-1:0] OVF_WORD = 64'h0000_0000_006F_7666;
  localparam logic [W-1:0] MAX_WORD = '1;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/gseq_sat_add.sv
// Combinational saturating add for the series accumulator.
// Ports:
//   acc    : running sum so far
//   term   : incoming term (may be the OVF sentinel)
//   sticky : sequence has already overflowed
//   sum_c  : acc+term, or OVF_WORD when ovf_c is set
//   ovf_c  : sticky, sentinel term, carry-out, or sum equal to all-ones
module gseq_sat_add
  import gseq_pkg::*;
#(
  parameter int unsigned AW = gseq_pkg::W
) (
  input  logic [AW-1:0] acc,
  input  logic [AW-1:0] term,
  input  logic          sticky,
  output logic [AW-1:0] sum_c,
  output logic          ovf_c
);

  logic [AW:0] raw;

  // One extra bit captures the carry-out.
  assign raw = {1'b0, acc} + {1'b0, term};

  // The all-ones sum is reserved so a saturated value is never mistaken for data.
  assign ovf_c = sticky
              || (term == AW'(OVF_WORD))
              || raw[AW]
              || (raw[AW-1:0] == AW'(MAX_WORD));

  assign sum_c = ovf_c ? AW'(OVF_WORD) : raw[AW-1:0];

endmodule

// File: rtl/gseq_series_acc.sv
// Series accumulator: turns a geometric term stream into running partial sums
// S_i = term_0 + ... + term_i, each emitted with its 1-based index. Overflow is
// sticky within a sequence and reported as the OVF sentinel.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   clear               : synchronous abort of the current sequence
//   in_valid/in_ready   : term handshake; in_term, in_last payload
//   out_valid/out_ready : partial-sum handshake; out_sum, out_idx, out_ovf,
//                         out_last payload
//   busy                : at least one term taken, sequence not finished
//   seq_done            : pulse after the final partial sum handshakes
module gseq_series_acc
  import gseq_pkg::*;
#(
  parameter int unsigned N  = gseq_pkg::N,
  parameter int unsigned SW = gseq_pkg::W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SW-1:0]            in_term,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SW-1:0]            out_sum,
  output logic [$clog2(N+1)-1:0]   out_idx,
  output logic                     out_ovf,
  output logic                     out_last,
  output logic                     busy,
  output logic                     seq_done
);

  localparam int unsigned IW = $clog2(N + 1);

  state_t          state;
  logic [SW-1:0]   acc;
  logic [IW-1:0]   cnt;
  logic            sticky;
  logic            ready_en;

  logic [SW-1:0]   add_sum_c;
  logic            add_ovf_c;
  logic [IW-1:0]   cnt_nxt_c;
  logic            last_c;
  logic            accept_c;
  logic            out_hs_c;

  gseq_sat_add #(.AW(SW)) u_sat_add (
    .acc    (acc),
    .term   (in_term),
    .sticky (sticky),
    .sum_c  (add_sum_c),
    .ovf_c  (add_ovf_c)
  );

  // ready_en holds in_ready low through reset and until the first edge after it.
  assign in_ready  = ready_en && (state == ACCUM) && (!out_valid || out_ready);
  assign accept_c  = in_valid && in_ready;
  assign out_hs_c  = out_valid && out_ready;
  assign cnt_nxt_c = IW'(cnt + IW'(1));
  // The N-th term always closes the sequence, so the count cannot run past N.
  assign last_c    = in_last || (cnt_nxt_c == IW'(N));

  // Sequence state, accumulator and registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      ready_en  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_idx   <= '0;
      out_ovf   <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      seq_done  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      seq_done <= 1'b0;
      if (clear) begin
        // Abort wins over any handshake this cycle; a pending beat is dropped.
        state     <= ACCUM;
        acc       <= '0;
        cnt       <= '0;
        sticky    <= 1'b0;
        out_valid <= 1'b0;
        out_sum   <= '0;
        out_idx   <= '0;
        out_ovf   <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        if (out_hs_c) begin
          out_valid <= 1'b0;
          if (out_last) begin
            state    <= ACCUM;
            acc      <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
            busy     <= 1'b0;
            seq_done <= 1'b1;
          end
        end
        // Accept is only possible in ACCUM, so it never collides with the
        // final-beat cleanup above; a same-cycle handshake is simply replaced.
        if (accept_c) begin
          out_valid <= 1'b1;
          out_sum   <= add_sum_c;
          out_idx   <= cnt_nxt_c;
          out_ovf   <= add_ovf_c;
          out_last  <= last_c;
          cnt       <= cnt_nxt_c;
          busy      <= 1'b1;
          if (add_ovf_c) begin
            sticky <= 1'b1;
          end else begin
            acc <= add_sum_c;
          end
          if (last_c) begin
            state <= DRAIN;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gseq_series_acc.sv
// Self-checking bench for gseq_series_acc: directed scenarios plus randomized
// sequences checked against a plain-arithmetic model of partial sums.
module tb_gseq_series_acc;
  import gseq_pkg::*;

  localparam int unsigned NT = 10;
  localparam int unsigned IW = $clog2(NT + 1);

  typedef struct packed {
    logic [63:0]   sum;
    logic [IW-1:0] idx;
    logic          ovf;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_term = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_sum;
  logic [IW-1:0] out_idx;
  logic          out_ovf;
  logic          out_last;
  logic          busy;
  logic          seq_done;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] seq_terms[$];
  bit          seq_use_last;
  int          ready_mode;   // 0: always ready, 1: 1010..., 2: random
  int          valid_mode;   // 0: always valid, 1: random gaps

  gseq_series_acc #(.N(NT), .SW(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_term   (in_term),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_idx   (out_idx),
    .out_ovf   (out_ovf),
    .out_last  (out_last),
    .busy      (busy),
    .seq_done  (seq_done)
  );

  always #5 clk = ~clk;

  // Drives seq_terms as one sequence and checks every output cycle by cycle.
  task automatic run_seq();
    beat_t       exp_q[$];
    beat_t       b, cur, held, e;
    logic [64:0] tot;
    logic [63:0] acc;
    bit          ovf = 0;
    int          len = seq_terms.size();
    int          ti = 0;
    int          cyc = 0;
    bit          acc_prev = 0, stall_prev = 0, got_first = 0;
    bit          last_acc = 0, done = 0, exp_valid = 0;
    bit          acc_now, hs, exp_ready;

    // Model: plain wide-integer sums, overflow once the sum reaches 2^64-1.
    acc = '0;
    for (int i = 0; i < len; i++) begin
      tot = 65'(acc) + 65'(seq_terms[i]);
      if (ovf || seq_terms[i] == OVF_WORD || tot >= 65'h0_FFFF_FFFF_FFFF_FFFF) begin
        ovf   = 1;
        b.sum = OVF_WORD;
      end else begin
        acc   = tot[63:0];
        b.sum = acc;
      end
      b.idx  = IW'(i + 1);
      b.ovf  = ovf;
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end

    while (!done) begin
      @(negedge clk);
      cur = {out_sum, out_idx, out_ovf, out_last};
      n_total++;
      if (seq_done !== 1'b0) $display("FAIL seq_done_early: got %b expected 0", seq_done);
      else n_pass++;
      n_total++;
      if (busy !== got_first) $display("FAIL busy: got %b expected %b", busy, got_first);
      else n_pass++;
      n_total++;
      if (out_valid !== exp_valid) $display("FAIL out_valid: got %b expected %b", out_valid, exp_valid);
      else n_pass++;
      if (acc_prev) begin
        n_total++;
        if (exp_q.size() == 0 || cur !== exp_q[0])
          $display("FAIL latency_beat: got %h expected %h", cur, (exp_q.size() != 0) ? exp_q[0] : beat_t'('0));
        else n_pass++;
      end
      if (stall_prev) begin
        n_total++;
        if (cur !== held || out_valid !== 1'b1)
          $display("FAIL stall_stable: got %h expected %h", cur, held);
        else n_pass++;
      end

      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = (ti < len) && (valid_mode == 0 || $urandom_range(0, 2) != 0);
      in_term  = (ti < len) ? seq_terms[ti] : {$urandom, $urandom};
      in_last  = seq_use_last && (ti == len - 1);
      #1;
      exp_ready = !last_acc && (!exp_valid || out_ready);
      n_total++;
      if (in_ready !== exp_ready) $display("FAIL in_ready: got %b expected %b", in_ready, exp_ready);
      else n_pass++;

      acc_now = in_valid && in_ready;
      hs      = out_valid && out_ready;
      if (hs) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_beat: got %h expected none", cur);
          done = 1;
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) $display("FAIL beat: got %h expected %h", cur, e);
          else n_pass++;
          if (e.last) done = 1;
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = cur;
      if (hs) exp_valid = 0;
      if (acc_now) begin
        exp_valid = 1;
        got_first = 1;
        ti++;
        if (ti == len) last_acc = 1;
      end
      acc_prev = acc_now;
      @(posedge clk);
      cyc++;
      if (!done && cyc > 400) begin
        n_total++;
        $display("FAIL timeout: got %0d beats left expected 0", exp_q.size());
        done = 1;
      end
    end

    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    n_total++;
    if ({seq_done, busy, out_valid} !== 3'b100)
      $display("FAIL seq_end: got done/busy/valid %b expected 100", {seq_done, busy, out_valid});
    else n_pass++;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_done: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if ({out_valid, out_sum, out_idx, out_ovf, out_last, busy, seq_done, in_ready} !== '0)
      $display("FAIL reset_outputs: got %h expected 0", {out_valid, out_sum, out_idx, out_ovf, out_last, busy, seq_done, in_ready});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL ready_before_edge: got %b expected 0", in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_edge: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    seq_terms = '{64'd2, 64'd60, 64'd1800, 64'd54000};
    seq_use_last = 1; ready_mode = 0; valid_mode = 0;
    run_seq();
  endtask

  task automatic test_overflow();
    seq_terms = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
    seq_use_last = 1; ready_mode = 0; valid_mode = 0;
    run_seq();
  endtask

  task automatic test_sentinel();
    seq_terms = '{64'd4, 64'd5, OVF_WORD, 64'd6, 64'd7};
    seq_use_last = 1; ready_mode = 0; valid_mode = 0;
    run_seq();
    seq_terms = '{64'd7};
    run_seq();
  endtask

  task automatic test_backpressure();
    seq_terms.delete();
    for (int i = 0; i < 7; i++) seq_terms.push_back(64'($urandom));
    seq_use_last = 1; ready_mode = 1; valid_mode = 0;
    run_seq();
  endtask

  task automatic test_full_n();
    seq_terms.delete();
    for (int i = 0; i < NT; i++) seq_terms.push_back(64'($urandom_range(0, 1000)));
    seq_use_last = 0; ready_mode = 0; valid_mode = 0;
    run_seq();
  endtask

  task automatic test_early_last();
    seq_terms = '{64'd11, 64'd22, 64'd33};
    seq_use_last = 1; ready_mode = 0; valid_mode = 0;
    run_seq();
    seq_terms = '{64'd100, 64'd200};
    run_seq();
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 12; s++) begin
      len = $urandom_range(1, NT);
      seq_terms.delete();
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 9))
          0:       seq_terms.push_back(OVF_WORD);
          1:       seq_terms.push_back({$urandom, $urandom});
          default: seq_terms.push_back(64'($urandom_range(0, 100000)));
        endcase
      end
      seq_use_last = (len < NT) ? 1'b1 : 1'($urandom_range(0, 1));
      ready_mode = 2; valid_mode = 1;
      run_seq();
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in_valid = 1'b1; in_term = 64'd5; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, busy} !== 2'b11) $display("FAIL pre_reset_state: got %b expected 11", {out_valid, busy});
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, out_sum, out_idx, out_ovf, out_last, busy, seq_done, in_ready} !== '0)
      $display("FAIL async_reset: got %h expected 0", {out_valid, out_sum, out_idx, out_ovf, out_last, busy, seq_done, in_ready});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    seq_terms = '{64'd3};
    seq_use_last = 1; ready_mode = 0; valid_mode = 0;
    run_seq();
  endtask

  task automatic test_clear();
    @(negedge clk);
    in_valid = 1'b1; in_term = 64'd4; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if ({out_valid, busy} !== 2'b11) $display("FAIL pre_clear_state: got %b expected 11", {out_valid, busy});
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    n_total++;
    if ({out_valid, busy, seq_done} !== 3'b000) $display("FAIL clear_drop: got %b expected 000", {out_valid, busy, seq_done});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({seq_done, in_ready} !== 2'b01) $display("FAIL clear_no_done: got %b expected 01", {seq_done, in_ready});
    else n_pass++;
    // clear and a would-be accept in the same cycle: clear wins.
    in_valid = 1'b1; in_term = 64'd8; clear = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    n_total++;
    if ({out_valid, busy} !== 2'b00) $display("FAIL clear_priority: got %b expected 00", {out_valid, busy});
    else n_pass++;
    seq_terms = '{64'd9};
    seq_use_last = 1; ready_mode = 0; valid_mode = 0;
    run_seq();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_sentinel();
    test_backpressure();
    test_full_n();
    test_early_last();
    test_random();
    test_async_reset();
    test_clear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
